// File: rtl/spi_target_regs_if.sv
// Bus between the SPI target and its surroundings: the SPI pins on one side,
// the register-file strobe/address/data port on the other.
interface spi_target_regs_if #(
  parameter int AW = 4
) ();
  logic          sck;
  logic          mosi;
  logic          nss;
  logic          miso;
  logic          miso_oe;
  logic          wr_stb;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          rd_stb;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;

  // The SPI target itself.
  modport slave (
    input  sck, mosi, nss, rd_data,
    output miso, miso_oe, wr_stb, wr_addr, wr_data, rd_stb, rd_addr, busy
  );

  // The SPI master plus register file that surround the target.
  modport master (
    output sck, mosi, nss, rd_data,
    input  miso, miso_oe, wr_stb, wr_addr, wr_data, rd_stb, rd_addr, busy
  );
endinterface

// File: rtl/spi_target_regs.sv
// SPI target (mode 0 semantics, optional inverted SCK) bridging a slow
// bit-banged master to an external 8-bit register file. First byte is a
// command (bit7 = read, low AW bits = start address); following bytes are
// written to, or read from, auto-incrementing addresses.
module spi_target_regs #(
  parameter int          CPOL = 0,
  parameter int          AW   = 4,
  parameter int          SYNC = 2,
  parameter logic [7:0]  ID   = 8'hA5
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  spi_target_regs_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WDATA, ST_RDATA} state_e;

  localparam logic CPOL_L = (CPOL != 0);

  logic [SYNC-1:0] sck_sync_q, mosi_sync_q, nss_sync_q;
  logic            sck_prev_q, nss_prev_q;
  logic            sck_s, mosi_s, nss_s;
  logic            rise_s, fall_s, nss_fall_s, nss_rise_s, byte_done_s;
  logic [7:0]      byte_s;

  state_e          state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [6:0]      rx_q, rx_d;
  logic [6:0]      tx_q, tx_d;
  logic            miso_q, miso_d;
  logic            load_q, load_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wr_stb_q, wr_stb_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            rd_stb_q, rd_stb_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            busy_q, busy_d;
  logic            rd_dly_q;
  logic [7:0]      rd_cap_q;

  // Synchronize the asynchronous SPI pins; SCK resets to its idle level so no false edge appears.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      sck_sync_q  <= {SYNC{CPOL_L}};
      mosi_sync_q <= '0;
      nss_sync_q  <= {SYNC{1'b1}};
      sck_prev_q  <= 1'b0;
      nss_prev_q  <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC-2:0], bus.sck};
      mosi_sync_q <= {mosi_sync_q[SYNC-2:0], bus.mosi};
      nss_sync_q  <= {nss_sync_q[SYNC-2:0], bus.nss};
      sck_prev_q  <= sck_s;
      nss_prev_q  <= nss_s;
    end
  end

  assign sck_s       = sck_sync_q[SYNC-1] ^ CPOL_L;
  assign mosi_s      = mosi_sync_q[SYNC-1];
  assign nss_s       = nss_sync_q[SYNC-1];
  assign rise_s      = ~nss_s & sck_s & ~sck_prev_q;
  assign fall_s      = ~nss_s & ~sck_s & sck_prev_q;
  assign nss_fall_s  = ~nss_s & nss_prev_q;
  assign nss_rise_s  = nss_s & ~nss_prev_q;
  assign byte_s      = {rx_q, mosi_s};
  assign byte_done_s = rise_s & (bitcnt_q == 3'd7);

  // Register-file read data is valid the cycle after RD_STB; capture it then for the next SCK fall.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      rd_dly_q <= 1'b0;
      rd_cap_q <= 8'h00;
    end else begin
      rd_dly_q <= rd_stb_q;
      if (rd_dly_q) begin
        rd_cap_q <= bus.rd_data;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q   <= ST_IDLE;
      bitcnt_q  <= 3'd0;
      rx_q      <= 7'h00;
      tx_q      <= 7'h00;
      miso_q    <= 1'b0;
      load_q    <= 1'b0;
      addr_q    <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      rd_stb_q  <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      load_q    <= load_d;
      addr_q    <= addr_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_stb_q  <= rd_stb_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic: nSS edges dominate; otherwise SCK rise shifts in, SCK fall shifts/loads out.
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    load_d    = load_q;
    addr_d    = addr_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_stb_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    busy_d    = ~nss_s;

    if (nss_rise_s) begin
      // Deselect discards any partial or just-completed byte.
      state_d  = ST_IDLE;
      bitcnt_d = 3'd0;
      miso_d   = 1'b0;
      load_d   = 1'b0;
    end else if (nss_fall_s) begin
      state_d  = ST_CMD;
      bitcnt_d = 3'd0;
      tx_d     = ID[6:0];
      miso_d   = ID[7];
      load_d   = 1'b0;
    end else if (rise_s && (state_q != ST_IDLE)) begin
      rx_d     = byte_s[6:0];
      bitcnt_d = bitcnt_q + 3'd1;
      if (byte_done_s) begin
        case (state_q)
          ST_CMD: begin
            addr_d = byte_s[AW-1:0];
            if (byte_s[7]) begin
              state_d   = ST_RDATA;
              rd_stb_d  = 1'b1;
              rd_addr_d = byte_s[AW-1:0];
              load_d    = 1'b1;
            end else begin
              state_d = ST_WDATA;
            end
          end
          ST_WDATA: begin
            wr_stb_d  = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = byte_s;
            addr_d    = addr_q + AW'(1);
          end
          ST_RDATA: begin
            rd_stb_d  = 1'b1;
            rd_addr_d = addr_q;
            load_d    = 1'b1;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end else begin
        load_d = load_q;
      end
    end else if (fall_s && (state_q != ST_IDLE)) begin
      if (load_q) begin
        // First fall after a read byte completes: present the prefetched register.
        tx_d   = rd_cap_q[6:0];
        miso_d = rd_cap_q[7];
        load_d = 1'b0;
        addr_d = addr_q + AW'(1);
      end else begin
        tx_d   = {tx_q[5:0], 1'b0};
        miso_d = tx_q[6];
      end
    end else begin
      state_d = state_q;
    end
  end

  assign bus.miso    = miso_q;
  assign bus.miso_oe = ~bus.nss;
  assign bus.wr_stb  = wr_stb_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rd_stb  = rd_stb_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.busy    = busy_q;

endmodule
